// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with a valid/ready handshake,
// a one-entry skid buffer, synchronous flush and NOP bubble insertion.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   flush              drops every held beat and any beat accepted this cycle
//   in_valid/in_ready  upstream handshake; in_ready is a flop (NOT skid_valid)
//   pcPlus1_in         upstream PC+1 (PC_W bits)
//   instruction_in     upstream instruction (INSTR_W bits)
//   out_valid/out_ready downstream handshake; out_valid is the main-register valid
//   pcPlus1_out        main-register PC+1, 0 when empty
//   instruction_out    main-register instruction, NOP_INSTR when empty
//   occupancy          number of held beats (0..2)
module pipe_stage_reg #(
    parameter int                 PC_W      = 12,
    parameter int                 INSTR_W   = 19,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pcPlus1_in,
    input  logic [INSTR_W-1:0] instruction_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pcPlus1_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [1:0]         occupancy
);

    logic               main_valid_q, main_valid_d;
    logic [PC_W-1:0]    main_pc_q,    main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic               skid_valid_q, skid_valid_d;
    logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic acc;
    logic drn;

    // in_ready comes straight from the skid flop, so out_ready never reaches it
    // combinationally; the skid entry absorbs the one beat that arrives while
    // downstream stalls.
    assign in_ready        = ~skid_valid_q;
    assign out_valid       = main_valid_q;
    assign pcPlus1_out     = main_pc_q;
    assign instruction_out = main_instr_q;
    assign occupancy       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    assign acc = in_valid & ~skid_valid_q;
    assign drn = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
        end else if (!main_valid_q) begin
            if (acc) begin
                main_valid_d = 1'b1;
                main_pc_d    = pcPlus1_in;
                main_instr_d = instruction_in;
            end
        end else if (!skid_valid_q) begin
            if (drn && acc) begin
                main_pc_d    = pcPlus1_in;
                main_instr_d = instruction_in;
            end else if (drn) begin
                // Main empties: present a bubble downstream.
                main_valid_d = 1'b0;
                main_pc_d    = '0;
                main_instr_d = NOP_INSTR;
            end else if (acc) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = pcPlus1_in;
                skid_instr_d = instruction_in;
            end
        end else if (drn) begin
            // Both full: the older skid beat moves up, skid frees for upstream.
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

endmodule
